// File: rtl/axiprotocol_pkg.sv
// Shared AXI protocol widths and enumerations used by the read slave and its
// address generator.
package axiprotocol;

  localparam int AXI_WIDTH = 32;
  localparam int AXI_SIZE  = 3;

  typedef enum logic [AXI_SIZE-2:0] {
    BURST_FIXED,
    BURST_INCR,
    BURST_WRAP,
    BURST_RSVD
  } burst_e;

  typedef enum logic [AXI_SIZE-2:0] {
    RESP_OKAY,
    RESP_EXOKAY,
    RESP_SLVERR,
    RESP_DECERR
  } resp_e;

  typedef enum logic {
    ST_IDLE,
    ST_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational AXI burst address stepper plus request legality check.
// Shared between the read slave and the future write slave.
module axi_rd_addr_gen
  import axiprotocol::*;
#(
  parameter int AW = AXI_WIDTH,
  parameter int LW = AXI_WIDTH / 8,
  parameter int SW = AXI_SIZE
) (
  input  logic [AW-1:0] addr_i,
  input  logic [LW-1:0] len_i,
  input  logic [SW-1:0] size_i,
  input  burst_e        burst_i,
  output logic [AW-1:0] next_addr_o,
  output logic          slverr_o
);

  localparam int MAX_SIZE = $clog2(AW / 8);

  logic [AW-1:0] step;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] incr_addr;
  logic          len_wrap_ok;

  always_comb begin
    step        = AW'(1) << size_i;
    wrap_mask   = ((AW'(len_i) + AW'(1)) << size_i) - AW'(1);
    incr_addr   = addr_i + step;
    len_wrap_ok = (len_i == LW'(1)) || (len_i == LW'(3)) ||
                  (len_i == LW'(7)) || (len_i == LW'(15));

    slverr_o = (size_i > SW'(MAX_SIZE)) || (burst_i == BURST_RSVD) ||
               ((burst_i == BURST_WRAP) && !len_wrap_ok);

    case (burst_i)
      BURST_INCR: next_addr_o = incr_addr;
      // Wrap keeps the aligned block base and steps only inside the window.
      BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_read_slave.sv
// AXI3 read-channel slave: one outstanding AR request, bursts served from a
// word-organised memory that is filled through a simple preload port.
module axi_read_slave
  import axiprotocol::*;
#(
  parameter int WIDTH     = AXI_WIDTH,
  parameter int SIZE      = AXI_SIZE,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  input  logic [WIDTH/8-1:0]           ARID,
  input  logic [WIDTH-1:0]             ARADDR,
  input  logic [WIDTH/8-1:0]           ARLEN,
  input  logic [SIZE-1:0]              ARSIZE,
  input  logic [SIZE-2:0]              ARBURST,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [WIDTH/8-1:0]           RID,
  output logic [WIDTH-1:0]             RDATA,
  output logic [SIZE-2:0]              RRESP,
  output logic                         RLAST,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [WIDTH-1:0]             mem_wdata
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int IW = WIDTH / 8;

  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic [WIDTH-1:0] mem_rd_q;

  rd_state_e        state_q,   state_d;
  logic             arready_q, arready_d;
  logic [IW-1:0]    id_q,      id_d;
  logic [WIDTH-1:0] addr_q,    addr_d;
  logic [IW-1:0]    len_q,     len_d;
  logic [SIZE-1:0]  size_q,    size_d;
  burst_e           burst_q,   burst_d;
  logic             slverr_q,  slverr_d;
  logic [IW-1:0]    beat_q,    beat_d;
  resp_e            resp_q,    resp_d;
  logic             data_ok_q, data_ok_d;

  logic             ar_hs;
  logic             r_hs;
  logic             last_beat;
  logic             load;
  logic             in_idle;
  logic [WIDTH-1:0] gen_addr;
  logic [IW-1:0]    gen_len;
  logic [SIZE-1:0]  gen_size;
  burst_e           gen_burst;
  logic [WIDTH-1:0] gen_next;
  logic             gen_slverr;
  logic [WIDTH-1:0] load_addr;
  logic             load_slverr;
  logic             load_decerr;
  logic [AW-1:0]    load_idx;
  logic             unused_lsb;

  // In IDLE the generator checks the incoming request; in DATA it steps the
  // captured burst, so one instance serves both.
  assign in_idle   = (state_q == ST_IDLE);
  assign gen_addr  = in_idle ? ARADDR : addr_q;
  assign gen_len   = in_idle ? ARLEN : len_q;
  assign gen_size  = in_idle ? ARSIZE : size_q;
  assign gen_burst = in_idle ? burst_e'(ARBURST) : burst_q;

  axi_rd_addr_gen #(
    .AW (WIDTH),
    .LW (IW),
    .SW (SIZE)
  ) u_addr_gen (
    .addr_i      (gen_addr),
    .len_i       (gen_len),
    .size_i      (gen_size),
    .burst_i     (gen_burst),
    .next_addr_o (gen_next),
    .slverr_o    (gen_slverr)
  );

  assign ar_hs     = ARVALID && arready_q;
  assign r_hs      = (state_q == ST_DATA) && RREADY;
  assign last_beat = (beat_q == len_q);
  assign load      = ar_hs || (r_hs && !last_beat);

  assign load_addr   = in_idle ? ARADDR : gen_next;
  assign load_slverr = in_idle ? gen_slverr : slverr_q;
  assign load_decerr = (load_addr[WIDTH-1:2] >= (WIDTH-2)'(MEM_DEPTH));
  assign load_idx    = load_addr[AW+1:2];
  assign unused_lsb  = ^load_addr[1:0];

  // Read is enabled only when a beat is loaded, so a preload to the word of
  // a pending beat cannot disturb the data already presented.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (load) begin
      mem_rd_q <= mem[load_idx];
    end
  end

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    slverr_d  = slverr_q;
    beat_d    = beat_q;
    resp_d    = resp_q;
    data_ok_d = data_ok_q;

    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          id_d      = ARID;
          addr_d    = ARADDR;
          len_d     = ARLEN;
          size_d    = ARSIZE;
          burst_d   = burst_e'(ARBURST);
          slverr_d  = gen_slverr;
          beat_d    = '0;
          arready_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        arready_d = 1'b0;
        if (r_hs) begin
          if (last_beat) begin
            arready_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            addr_d = gen_next;
            beat_d = beat_q + IW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      if (load_slverr) begin
        resp_d = RESP_SLVERR;
      end else if (load_decerr) begin
        resp_d = RESP_DECERR;
      end else begin
        resp_d = RESP_OKAY;
      end
      data_ok_d = !load_slverr && !load_decerr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      slverr_q  <= 1'b0;
      beat_q    <= '0;
      resp_q    <= RESP_OKAY;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      slverr_q  <= slverr_d;
      beat_q    <= beat_d;
      resp_q    <= resp_d;
      data_ok_q <= data_ok_d;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = (state_q == ST_DATA);
  assign RLAST   = RVALID && last_beat;
  assign RID     = id_q;
  assign RRESP   = resp_q;
  assign RDATA   = data_ok_q ? mem_rd_q : '0;

endmodule
